// File: rtl/wsn_pkg.sv
// Shared types and constants for the WSN transmit path: packet type codes,
// scheduler states, request-source indices and the fixed-priority picker.
package wsn_pkg;

    typedef enum logic [2:0] {
        HB   = 3'b000,
        CHE  = 3'b001,
        INV  = 3'b010,
        MR   = 3'b011,
        CHT  = 3'b100,
        DATA = 3'b101,
        SOS  = 3'b110,
        NONE = 3'b111
    } pkt_type_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_TX    = 2'd3
    } sched_state_t;

    // Neighbor index value meaning "no neighbor selected"
    localparam logic [5:0] NT_INVALID = 6'b100000;

    // Pending-request bit positions; lower index = higher priority
    localparam int         NUM_SRC   = 7;
    localparam logic [2:0] SRC_CHT   = 3'd0;
    localparam logic [2:0] SRC_MR    = 3'd1;
    localparam logic [2:0] SRC_CHINV = 3'd2;
    localparam logic [2:0] SRC_INV   = 3'd3;
    localparam logic [2:0] SRC_HB    = 3'd4;
    localparam logic [2:0] SRC_SOS   = 3'd5;
    localparam logic [2:0] SRC_DATA  = 3'd6;

    // Index of the highest-priority (lowest-numbered) set pending bit
    function automatic logic [2:0] prio_pick(input logic [NUM_SRC-1:0] pend);
        logic [2:0] pick;
        pick = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick = 3'(i);
            end
        end
        return pick;
    endfunction

    // Packet type handed to the packer for each request source.
    // The CH's own INV goes out with the ordinary INV type code.
    function automatic pkt_type_t src_type(input logic [2:0] src);
        pkt_type_t t;
        case (src)
            SRC_CHT:   t = CHT;
            SRC_MR:    t = MR;
            SRC_CHINV: t = INV;
            SRC_INV:   t = INV;
            SRC_HB:    t = HB;
            SRC_SOS:   t = SOS;
            SRC_DATA:  t = DATA;
            default:   t = NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/down_timer.sv
// One-shot down counter: loads only when idle, counts to zero, and flags
// the cycle in which it reaches zero.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_running,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Count down while nonzero; a load request is ignored while running
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end else if (i_load) begin
            r_count <= i_load_val;
        end
    end

    assign o_running = (r_count != '0);
    // High in the last counting cycle, i.e. the count reaches 0 at the next edge
    assign o_expired = (r_count == WIDTH'(1));

endmodule

// File: rtl/pkt_tx_sched.sv
// Transmit scheduler: latches send requests, runs the MR and CHT timers,
// picks the highest-priority pending request and sequences the reward
// packer (start pulse, assembly done) and the link layer (tx_ready).
module pkt_tx_sched
    import wsn_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 32,
    parameter int MR_TIMEOUT    = 15,
    parameter int CHT_TIMEOUT   = 15,
    parameter int INV_MAX_HOPS  = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pkt_valid,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic                  role,
    input  logic                  low_E,
    input  logic                  iHaveData,
    input  logic [5:0]            neighborCount,
    input  logic                  reward_done,
    input  logic                  tx_ready,
    output logic                  reward_en,
    output logic [2:0]            sel_type,
    output logic [5:0]            nTableIndex,
    output logic                  busy,
    output logic                  hb_lock
);

    localparam int TMR_MAX = (MR_TIMEOUT > CHT_TIMEOUT) ? MR_TIMEOUT : CHT_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    sched_state_t         r_state;
    pkt_type_t            r_sel;
    logic [5:0]           r_idx;
    logic [2:0]           r_src;
    logic [NUM_SRC-1:0]   r_pend;
    logic                 r_hb_lock;
    logic                 r_role_d;
    logic                 r_low_e_d;

    pkt_type_t            w_type;
    logic [5:0]           w_nb;
    logic [2:0]           w_pick;
    logic                 w_any;
    logic [6:0]           w_idx_next;
    logic                 w_tx_done;
    logic                 w_cht_more;
    logic                 w_chinv_done;
    logic                 w_is_inv;
    logic                 w_data_for_me;
    logic [NUM_SRC-1:0]   w_pend_set;
    logic [NUM_SRC-1:0]   w_pend_clr;
    logic                 w_mr_load;
    logic                 w_mr_running;
    logic                 w_mr_expired;
    logic                 w_cht_load;
    logic                 w_cht_running;
    logic                 w_cht_expired;

    assign w_type        = pkt_type_t'(fPacketType);
    assign w_nb          = (neighborCount > 6'(MAX_NEIGHBORS)) ? 6'(MAX_NEIGHBORS) : neighborCount;
    assign w_pick        = prio_pick(r_pend);
    assign w_any         = |r_pend;
    assign w_idx_next    = {1'b0, r_idx} + 7'd1;
    assign w_tx_done     = (r_state == S_TX) && tx_ready;
    assign w_cht_more    = (r_src == SRC_CHT) && (w_idx_next < {1'b0, w_nb});
    assign w_chinv_done  = w_tx_done && (r_src == SRC_CHINV);
    assign w_is_inv      = pkt_valid && (w_type == INV);
    assign w_data_for_me = pkt_valid && (w_type == DATA) && iAmDestination;

    // MR timer starts on a received INV when acting as a cluster member
    assign w_mr_load  = w_is_inv && !role && !w_mr_running;
    // CHT timer starts once the CH's own INV has left the node
    assign w_cht_load = w_chinv_done && !w_cht_running;

    down_timer #(.WIDTH(TMR_W)) u_mr_timer (
        .clk        (clk),
        .nrst       (nrst),
        .i_load     (w_mr_load),
        .i_load_val (TMR_W'(MR_TIMEOUT)),
        .o_running  (w_mr_running),
        .o_expired  (w_mr_expired)
    );

    down_timer #(.WIDTH(TMR_W)) u_cht_timer (
        .clk        (clk),
        .nrst       (nrst),
        .i_load     (w_cht_load),
        .i_load_val (TMR_W'(CHT_TIMEOUT)),
        .o_running  (w_cht_running),
        .o_expired  (w_cht_expired)
    );

    // New requests from received packets, local events and timers
    always_comb begin
        w_pend_set            = '0;
        w_pend_set[SRC_CHT]   = w_cht_expired;
        w_pend_set[SRC_MR]    = w_mr_expired;
        w_pend_set[SRC_CHINV] = role && !r_role_d;
        w_pend_set[SRC_INV]   = w_is_inv && (hopsFromCH < WORD_WIDTH'(INV_MAX_HOPS));
        w_pend_set[SRC_HB]    = pkt_valid && (w_type == HB) && !r_hb_lock;
        w_pend_set[SRC_SOS]   = (pkt_valid && (w_type == SOS) && iAmDestination)
                              || (low_E && !r_low_e_d);
        w_pend_set[SRC_DATA]  = w_data_for_me || ((r_state == S_IDLE) && iHaveData);
    end

    // Requests retired by the scheduler; CHT stays pending for the whole walk
    always_comb begin
        w_pend_clr = '0;
        if ((r_state == S_IDLE) && w_any) begin
            if (w_pick != SRC_CHT || w_nb == 6'd0) begin
                w_pend_clr[w_pick] = 1'b1;
            end
        end
        if (w_tx_done && (r_src == SRC_CHT) && !w_cht_more) begin
            w_pend_clr[SRC_CHT] = 1'b1;
        end
    end

    // Sticky pending bits, heartbeat lock and edge-detect history
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pend    <= '0;
            r_hb_lock <= 1'b0;
            r_role_d  <= 1'b0;
            r_low_e_d <= 1'b0;
        end else begin
            r_pend    <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_role_d  <= role;
            r_low_e_d <= low_E;
            if (w_pend_set[SRC_HB]) begin
                r_hb_lock <= 1'b1;
            end else if (w_data_for_me) begin
                r_hb_lock <= 1'b0;
            end
        end
    end

    // Issue sequencer: arbitrate, start packer, wait for packer and link layer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_sel   <= NONE;
            r_idx   <= NT_INVALID;
            r_src   <= SRC_CHT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A CHT with no neighbors is simply dropped (bit cleared above)
                    if (w_any && !(w_pick == SRC_CHT && w_nb == 6'd0)) begin
                        r_src   <= w_pick;
                        r_sel   <= src_type(w_pick);
                        r_idx   <= (w_pick == SRC_CHT) ? 6'd0 : NT_INVALID;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (reward_done) begin
                        r_state <= S_TX;
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        if (w_cht_more) begin
                            r_idx   <= w_idx_next[5:0];
                            r_state <= S_ISSUE;
                        end else begin
                            r_sel   <= NONE;
                            r_idx   <= NT_INVALID;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign reward_en   = (r_state == S_ISSUE);
    assign sel_type    = r_sel;
    assign nTableIndex = r_idx;
    assign busy        = (r_state != S_IDLE);
    assign hb_lock     = r_hb_lock;

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Directed bench for pkt_tx_sched: stimulus pushes the expected packer
// requests into a queue, a monitor pops and compares on every reward_en,
// and a responder plays the reward packer and link layer.
module tb_pkt_tx_sched;
    import wsn_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        pkt_valid;
    logic [2:0]  fPacketType;
    logic        iAmDestination;
    logic [15:0] hopsFromCH;
    logic        role;
    logic        low_E;
    logic        iHaveData;
    logic [5:0]  neighborCount;
    logic        reward_done;
    logic        tx_ready;
    logic        reward_en;
    logic [2:0]  sel_type;
    logic [5:0]  nTableIndex;
    logic        busy;
    logic        hb_lock;

    typedef struct {
        logic [2:0] sel;
        logic [5:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   mr_cyc = 0;
    int   cht_first_cyc = 0;
    int   inv_tx_cyc = 0;
    int   rd_delay = 2;
    int   tx_delay = 2;
    logic prev_busy = 1'b0;

    pkt_tx_sched dut (
        .clk            (clk),
        .nrst           (nrst),
        .pkt_valid      (pkt_valid),
        .fPacketType    (fPacketType),
        .iAmDestination (iAmDestination),
        .hopsFromCH     (hopsFromCH),
        .role           (role),
        .low_E          (low_E),
        .iHaveData      (iHaveData),
        .neighborCount  (neighborCount),
        .reward_done    (reward_done),
        .tx_ready       (tx_ready),
        .reward_en      (reward_en),
        .sel_type       (sel_type),
        .nTableIndex    (nTableIndex),
        .busy           (busy),
        .hb_lock        (hb_lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [5:0] i);
        exp_t e;
        e.sel = s;
        e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic send_pkt(input logic [2:0] t, input logic d, input logic [15:0] h);
        pkt_valid      = 1'b1;
        fPacketType    = t;
        iAmDestination = d;
        hopsFromCH     = h;
        tick();
        pkt_valid      = 1'b0;
        iAmDestination = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL %s: timeout, %0d issues outstanding busy=%b, expected 0 outstanding and idle",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pulses < target && n < budget) begin
            tick();
            n++;
        end
        check(name, (pulses >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: one line per issued packet, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst && reward_en) begin
                pulses++;
                $display("issue cyc=%0d sel_type=%b nTableIndex=%b", cyc, sel_type, nTableIndex);
                if (sel_type == MR) mr_cyc = cyc;
                if (sel_type == CHT && nTableIndex == 6'd0) cht_first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got sel_type=%b nTableIndex=%b, expected no issue",
                             sel_type, nTableIndex);
                end else begin
                    e = exp_q.pop_front();
                    check("sel_type", {29'd0, sel_type}, {29'd0, e.sel});
                    check("nTableIndex", {26'd0, nTableIndex}, {26'd0, e.idx});
                end
                if (sel_type != CHT || nTableIndex == 6'd0)
                    check("busy_before_issue", {31'd0, prev_busy}, 32'd0);
            end
            prev_busy = busy;
        end
    end

    // Responder: reward packer then link layer, with adjustable latencies
    initial begin
        logic [2:0] s;
        reward_done = 1'b0;
        tx_ready    = 1'b0;
        forever begin
            if (nrst === 1'b1 && reward_en === 1'b1) begin
                repeat (rd_delay) tick();
                reward_done = 1'b1;
                tick();
                reward_done = 1'b0;
                repeat (tx_delay) tick();
                tx_ready = 1'b1;
                s = sel_type;
                tick();
                tx_ready = 1'b0;
                if (s == INV) inv_tx_cyc = cyc;
            end else begin
                tick();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int t_inv;
        nrst           = 1'b0;
        pkt_valid      = 1'b0;
        fPacketType    = 3'b000;
        iAmDestination = 1'b0;
        hopsFromCH     = 16'd0;
        role           = 1'b0;
        low_E          = 1'b0;
        iHaveData      = 1'b0;
        neighborCount  = 6'd0;
        repeat (3) tick();

        // Reset state
        check("rst_reward_en", {31'd0, reward_en}, 32'd0);
        check("rst_sel_type", {29'd0, sel_type}, 32'd7);
        check("rst_nTableIndex", {26'd0, nTableIndex}, 32'd32);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hb_lock", {31'd0, hb_lock}, 32'd0);
        nrst = 1'b1;
        repeat (2) tick();

        // HB rippled once, lock cleared by Data for this node
        p = pulses;
        push(HB, NT_INVALID);
        send_pkt(HB, 1'b0, 16'd0);
        check("hb_lock_set", {31'd0, hb_lock}, 32'd1);
        repeat (10) tick();
        send_pkt(HB, 1'b0, 16'd0);
        wait_drain(60, "hb_drain");
        check("hb_single_issue", pulses, p + 1);
        check("hb_lock_held", {31'd0, hb_lock}, 32'd1);
        push(DATA, NT_INVALID);
        send_pkt(DATA, 1'b1, 16'd0);
        check("hb_lock_clr", {31'd0, hb_lock}, 32'd0);
        wait_drain(60, "data_drain");

        // INV within hop limit: ripple then MR 16 cycles after the INV edge
        push(INV, NT_INVALID);
        push(MR, NT_INVALID);
        send_pkt(INV, 1'b0, 16'd3);
        t_inv = cyc;
        wait_drain(80, "inv3_drain");
        check("mr_delay_hops3", mr_cyc - t_inv, 32'd16);

        // INV at hop limit: no ripple, MR still issued
        push(MR, NT_INVALID);
        send_pkt(INV, 1'b0, 16'd4);
        t_inv = cyc;
        wait_drain(80, "inv4_drain");
        check("mr_delay_hops4", mr_cyc - t_inv, 32'd16);

        // Becoming CH with 3 neighbors: chINV then CHT walk 0,1,2
        neighborCount = 6'd3;
        push(INV, NT_INVALID);
        push(CHT, 6'd0);
        push(CHT, 6'd1);
        push(CHT, 6'd2);
        role = 1'b1;
        wait_drain(150, "cht3_drain");
        check("cht_delay", cht_first_cyc - inv_tx_cyc, 32'd16);
        check("cht_idx_restored", {26'd0, nTableIndex}, 32'd32);
        check("cht_sel_restored", {29'd0, sel_type}, 32'd7);
        role = 1'b0;
        repeat (3) tick();

        // Becoming CH with no neighbors: chINV only, CHT silently dropped
        neighborCount = 6'd0;
        push(INV, NT_INVALID);
        role = 1'b1;
        wait_drain(60, "cht0_drain");
        p = pulses;
        repeat (40) tick();
        check("cht0_no_issue", pulses, p);
        check("cht0_idle", {31'd0, busy}, 32'd0);
        role = 1'b0;
        tick();

        // Local low-energy edge and local data
        push(SOS, NT_INVALID);
        low_E = 1'b1;
        wait_drain(40, "lowe_drain");
        low_E = 1'b0;
        push(DATA, NT_INVALID);
        iHaveData = 1'b1;
        tick();
        iHaveData = 1'b0;
        wait_drain(40, "ihd_drain");

        // Priority while busy: MR beats HB beats DATA
        tx_delay = 25;
        push(INV, NT_INVALID);
        push(MR, NT_INVALID);
        push(HB, NT_INVALID);
        push(DATA, NT_INVALID);
        send_pkt(INV, 1'b0, 16'd3);
        repeat (4) tick();
        send_pkt(HB, 1'b0, 16'd0);
        send_pkt(DATA, 1'b1, 16'd0);
        repeat (3) tick();
        tx_delay = 2;
        wait_drain(150, "prio_drain");

        // Link layer stalls: nothing new starts while waiting for tx_ready
        tx_delay = 20;
        push(SOS, NT_INVALID);
        push(HB, NT_INVALID);
        p = pulses;
        send_pkt(SOS, 1'b1, 16'd0);
        wait_pulses(p + 1, 20, "stall_first_issue");
        repeat (5) tick();
        p = pulses;
        send_pkt(HB, 1'b0, 16'd0);
        repeat (14) tick();
        check("stall_no_issue", pulses, p);
        check("stall_busy", {31'd0, busy}, 32'd1);
        wait_drain(80, "stall_drain");
        tx_delay = 2;

        // Asynchronous reset while waiting for the packer
        rd_delay = 12;
        push(DATA, NT_INVALID);
        p = pulses;
        send_pkt(DATA, 1'b1, 16'd0);
        wait_pulses(p + 1, 20, "rst_issue");
        repeat (3) tick();
        send_pkt(HB, 1'b0, 16'd0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_hb_lock", {31'd0, hb_lock}, 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_reward_en", {31'd0, reward_en}, 32'd0);
        check("async_rst_sel_type", {29'd0, sel_type}, 32'd7);
        check("async_rst_nTableIndex", {26'd0, nTableIndex}, 32'd32);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_hb_lock", {31'd0, hb_lock}, 32'd0);
        tick();
        nrst = 1'b1;
        rd_delay = 2;
        repeat (40) tick();
        check("post_rst_no_issue", pulses, p + 1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
